int2ascii_tx: RTL and testbench
===============================

// Module: int2ascii_tx
// PURPOSE
//  Transmit-side counterpart of the ASCII-to-integer receiver path. Takes one
//  unsigned binary integer and emits its decimal ASCII digits as a byte stream,
//  most significant digit first, for insertion into outgoing FIX fields.
//  Uses iterative double-dabble (shift-add-3) conversion, suppresses leading
//  zeros, and can optionally append the FIX SOH delimiter after the last digit.
// PARAMETERS
//  WIDTH      16     bit width of value_i
//  DIGITS     5      BCD digit count; >= ceil(WIDTH*log10(2)), checked at elaboration
//  APPEND_SOH 0      1: emit SOH_CHAR after the last digit
//  SOH_CHAR   8'h01  delimiter byte
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid_i in   1      value_i valid
//  value_i    in   WIDTH  unsigned integer to convert
//  in_ready_o out  1      block idle and able to accept a value
//  data_o     out  8      ASCII byte
//  valid_o    out  1      data_o valid
//  ready_i    in   1      downstream accepts data_o
//  last_o     out  1      data_o is the final byte of this field
//  done_o     out  1      one-cycle pulse after the final byte is transferred
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; in_ready_o=1, valid_o=0, data_o=8'h00,
//   last_o=0, done_o=0; BCD/shift registers cleared; any field in flight is discarded.
//  States: IDLE -> CONVERT -> EMIT -> (TERM if APPEND_SOH) -> IDLE.
//  IDLE: in_ready_o=1. Accept on in_valid_i&in_ready_o at edge: load value_i into
//   shift reg, clear BCD, cnt=WIDTH, go CONVERT. in_valid_i is ignored outside IDLE.
//  CONVERT: one bit per cycle for exactly WIDTH cycles: each BCD digit >=5 gets +3,
//   then {bcd,shift} <<= 1. On the final iteration, a combinational
//   leading-zero scan latches idx = index of the most significant nonzero digit
//   (0 if all digits are zero, so value 0 emits "0"); go EMIT.
//  EMIT: valid_o=1, data_o=8'h30+bcd[idx]. On valid_o&ready_i: if idx>0, idx--;
//   else go TERM (APPEND_SOH=1) or IDLE. last_o=1 on digit idx==0 only when APPEND_SOH=0.
//  TERM: valid_o=1, data_o=SOH_CHAR, last_o=1; on ready_i go IDLE.
//  done_o=1 for the single cycle after the final handshake; in_ready_o is 1 in
//   the same cycle (back-to-back accept is legal there).
//  Latency: accept edge at cycle 0 -> valid_o first high in cycle WIDTH+1.
//   With ready_i held high, one byte is transferred per cycle.
//  Backpressure: while valid_o&!ready_i, data_o and last_o are held stable.
//   valid_o never drops before the handshake.
//  ready_i is a don't-care while valid_o=0. Arithmetic is unsigned only, with
//   no wrap. A value wider than DIGITS digits cannot occur because of the
//   elaboration check.
//  Outputs are registered; in_ready_o is decoded from state==IDLE.
// TESTING
//  123, ready_i=1 -> 8'h31,8'h32,8'h33 on consecutive cycles; first valid_o 17 cycles
//   after accept; last_o only on 8'h33; done_o pulses once on the next cycle.
//  0 -> single byte 8'h30 with last_o=1; no leading-zero bytes emitted.
//  65535 -> 8'h36,8'h35,8'h35,8'h33,8'h35 (max value, all 5 digits, no overflow).
//  407, ready_i low 3 cycles during 2nd byte -> 8'h30 held stable with valid_o=1
//   throughout; sequence 34,30,37 intact.
//  APPEND_SOH=1, value 7 -> 8'h37 (last_o=0), then 8'h01 (last_o=1); done_o after SOH.
//  rst pulsed mid-EMIT of 9999 -> valid_o=0 and in_ready_o=1 immediately.
//   Next value 42 -> 8'h34,8'h32 with no residue from the aborted field.

Source files
------------

// File: rtl/int2ascii_tx.sv
`default_nettype none
// ============================================================================
//  Module   : int2ascii_tx
//  Purpose  : Converts an unsigned binary integer to its decimal ASCII digit
//             stream (most significant digit first, leading zeros dropped)
//             using iterative double-dabble, with an optional trailing FIX
//             SOH delimiter. Valid/ready byte output with backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module int2ascii_tx #(
  parameter int         WIDTH      = 16,
  parameter int         DIGITS     = 5,
  parameter bit         APPEND_SOH = 1'b0,
  parameter logic [7:0] SOH_CHAR   = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             in_ready_o,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic             done_o
);

  // Minimum digit count = ceil(WIDTH * log10(2)), in fixed point.
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
  localparam int BCDW       = DIGITS * 4;
  localparam int IDXW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW       = $clog2(WIDTH + 1);

  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $error("int2ascii_tx: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_EMIT    = 2'd2,
    S_TERM    = 2'd3
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shift_reg;
  logic [BCDW-1:0]   bcd;
  logic [CNTW-1:0]   cnt;
  logic [IDXW-1:0]   idx;

  logic [BCDW-1:0]   bcd_adj;
  logic [BCDW-1:0]   bcd_next;
  logic [IDXW-1:0]   lz_idx;
  logic [IDXW-1:0]   idx_dec;

  // Pick one BCD digit out of the packed vector by digit index.
  function automatic logic [3:0] digit_at(input logic [BCDW-1:0] b,
                                          input logic [IDXW-1:0] k);
    digit_at = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (k == IDXW'(i)) digit_at = b[4*i +: 4];
    end
  endfunction

  // Add-3 correction for every BCD digit that would overflow on doubling.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign bcd_adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? (bcd[4*d +: 4] + 4'd3)
                                                        : bcd[4*d +: 4];
  end

  // Shift the next binary bit into the corrected BCD register.
  assign bcd_next = {bcd_adj[BCDW-2:0], shift_reg[WIDTH-1]};
  assign idx_dec  = idx - IDXW'(1);

  // Leading-zero scan: index of the highest nonzero digit, 0 when all are zero.
  always_comb begin
    lz_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_next[4*i +: 4] != 4'd0) lz_idx = IDXW'(i);
    end
  end

  assign in_ready_o = (state == S_IDLE);

  // Main controller: accept, convert one bit per cycle, then stream digits.
  // Entering EMIT spends one cycle loading the first byte, giving the
  // WIDTH+1 cycle accept-to-valid latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bcd       <= '0;
      cnt       <= '0;
      idx       <= '0;
      data_o    <= 8'h00;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            shift_reg <= value_i;
            bcd       <= '0;
            cnt       <= CNTW'(WIDTH);
            state     <= S_CONVERT;
          end
        end

        S_CONVERT: begin
          bcd       <= bcd_next;
          shift_reg <= shift_reg << 1;
          cnt       <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            idx   <= lz_idx;
            state <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (!valid_o) begin
            valid_o <= 1'b1;
            data_o  <= {4'h3, digit_at(bcd, idx)};
            last_o  <= (idx == '0) && (APPEND_SOH == 1'b0);
          end else if (ready_i) begin
            if (idx != '0) begin
              idx    <= idx_dec;
              data_o <= {4'h3, digit_at(bcd, idx_dec)};
              last_o <= (idx_dec == '0) && (APPEND_SOH == 1'b0);
            end else if (APPEND_SOH) begin
              data_o <= SOH_CHAR;
              last_o <= 1'b1;
              state  <= S_TERM;
            end else begin
              valid_o <= 1'b0;
              last_o  <= 1'b0;
              done_o  <= 1'b1;
              state   <= S_IDLE;
            end
          end
        end

        S_TERM: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            done_o  <= 1'b1;
            state   <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int2ascii_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int2ascii_tx
//  Purpose  : Directed self-checking bench for int2ascii_tx (plain and SOH
//             variants) with hand-computed ASCII byte sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_int2ascii_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid0, in_valid1;
  logic [15:0] value;
  logic        ready;

  logic       in_ready0, valid0, last0, done0;
  logic [7:0] data0;
  logic       in_ready1, valid1, last1, done1;
  logic [7:0] data1;

  logic       sel;
  logic       o_in_ready, o_valid, o_last, o_done;
  logic [7:0] o_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b [0:7];

  always #5 clk = ~clk;

  int2ascii_tx #(.WIDTH(16), .DIGITS(5), .APPEND_SOH(1'b0), .SOH_CHAR(8'h01)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid0), .value_i(value),
    .in_ready_o(in_ready0), .data_o(data0), .valid_o(valid0), .ready_i(ready),
    .last_o(last0), .done_o(done0)
  );

  int2ascii_tx #(.WIDTH(16), .DIGITS(5), .APPEND_SOH(1'b1), .SOH_CHAR(8'h01)) dut_soh (
    .clk(clk), .rst(rst), .in_valid_i(in_valid1), .value_i(value),
    .in_ready_o(in_ready1), .data_o(data1), .valid_o(valid1), .ready_i(ready),
    .last_o(last1), .done_o(done1)
  );

  assign o_in_ready = sel ? in_ready1 : in_ready0;
  assign o_valid    = sel ? valid1    : valid0;
  assign o_last     = sel ? last1     : last0;
  assign o_done     = sel ? done1     : done0;
  assign o_data     = sel ? data1     : data0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand one value to the selected DUT; returns after the accept edge.
  task automatic send(input logic s, input logic [15:0] v);
    int guard;
    sel   = s;
    guard = 0;
    while (!o_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_before_send", {31'd0, o_in_ready}, 32'd1);
    value = v;
    if (s) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  // Wait for the first byte; returns the number of edges since accept.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("valid_timeout", {31'd0, o_valid}, 32'd1);
  endtask

  // Full field: send, check latency, check every byte and the done pulse.
  task automatic run_field(input logic s, input logic [15:0] v, input int n,
                           input int stall_k, input int exp_lat);
    int lat;
    send(s, v);
    wait_valid(lat);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    for (int k = 0; k < n; k++) begin
      check("valid", {31'd0, o_valid}, 32'd1);
      check("data", {24'd0, o_data}, {24'd0, exp_b[k]});
      check("last", {31'd0, o_last}, (k == n - 1) ? 32'd1 : 32'd0);
      check("done_early", {31'd0, o_done}, 32'd0);
      if (k == stall_k) begin
        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          tick();
          check("stall_valid", {31'd0, o_valid}, 32'd1);
          check("stall_data", {24'd0, o_data}, {24'd0, exp_b[k]});
          check("stall_last", {31'd0, o_last}, (k == n - 1) ? 32'd1 : 32'd0);
        end
        ready = 1'b1;
      end
      tick();
    end
    check("done_pulse", {31'd0, o_done}, 32'd1);
    check("in_ready_at_done", {31'd0, o_in_ready}, 32'd1);
    check("valid_after", {31'd0, o_valid}, 32'd0);
    tick();
    check("done_once", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    value     = '0;
    ready     = 1'b1;
    sel       = 1'b0;
    repeat (3) tick();

    check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_data", {24'd0, data0}, 32'd0);
    check("rst_last", {31'd0, last0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    rst = 1'b0;
    tick();

    // 123: three digits, latency WIDTH+1
    exp_b[0] = 8'h31; exp_b[1] = 8'h32; exp_b[2] = 8'h33;
    run_field(1'b0, 16'd123, 3, -1, 17);

    // 0: single "0"
    exp_b[0] = 8'h30;
    run_field(1'b0, 16'd0, 1, -1, 17);

    // 65535: all five digits
    exp_b[0] = 8'h36; exp_b[1] = 8'h35; exp_b[2] = 8'h35; exp_b[3] = 8'h33; exp_b[4] = 8'h35;
    run_field(1'b0, 16'd65535, 5, -1, 17);

    // 407 with a 3-cycle stall on the second byte (embedded zero)
    exp_b[0] = 8'h34; exp_b[1] = 8'h30; exp_b[2] = 8'h37;
    run_field(1'b0, 16'd407, 3, 1, -1);

    // 10000: trailing zeros kept
    exp_b[0] = 8'h31; exp_b[1] = 8'h30; exp_b[2] = 8'h30; exp_b[3] = 8'h30; exp_b[4] = 8'h30;
    run_field(1'b0, 16'd10000, 5, -1, -1);

    // SOH variant: 7 then delimiter
    exp_b[0] = 8'h37; exp_b[1] = 8'h01;
    run_field(1'b1, 16'd7, 2, -1, 17);

    // Reset mid-EMIT of 9999, then 42 must be clean
    send(1'b0, 16'd9999);
    wait_valid(lat);
    check("abort_b0", {24'd0, data0}, 32'h39);
    tick();
    check("abort_b1", {24'd0, data0}, 32'h39);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", {31'd0, valid0}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready0}, 32'd1);
    check("abort_last", {31'd0, last0}, 32'd0);
    #2 rst = 1'b0;
    tick();
    exp_b[0] = 8'h34; exp_b[1] = 8'h32;
    run_field(1'b0, 16'd42, 2, -1, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
